// File: rtl/bus_drvr_fifo_bank_if.sv
// bus_drvr_fifo_bank_if: agent-write / DUT-pop handshake bundle for the driver FIFO bank
interface bus_drvr_fifo_bank_if #(
  parameter int NCH     = 4,
  parameter int PCKG_SZ = 16,
  parameter int CW      = 4
);
  logic [NCH-1:0]         wr_en, pop, clr_ovf, pndng, full, overflow;
  logic [NCH*PCKG_SZ-1:0] wr_data, D_pop;
  logic [NCH*CW-1:0]      count;
  modport master (output wr_en, wr_data, pop, clr_ovf, input pndng, D_pop, full, count, overflow);
  modport slave (input wr_en, wr_data, pop, clr_ovf, output pndng, D_pop, full, count, overflow);
endinterface

// File: rtl/bus_drvr_fifo_bank.sv
// bus_drvr_fifo_bank: per-driver independent FWFT FIFOs with occupancy, sticky overflow and full-policy
module bus_drvr_fifo_bank #(
  parameter int BITS      = 1,
  parameter int DRVRS     = 4,
  parameter int PCKG_SZ   = 16,
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 0
) (
  input logic                clk,
  input logic                reset,
  bus_drvr_fifo_bank_if.slave bus
);
  localparam int NCH = BITS * DRVRS;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic OVW = 1'(OVERWRITE != 0);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PCKG_SZ-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, pnd, is_full, do_pop, ovf_ev, do_wr, adv_rd;
    // next state: a write into a full channel without a pop either drops or evicts the head
    always_comb begin
      pnd     = cnt_q != '0;
      is_full = cnt_q == FULL_CNT;
      do_pop  = bus.pop[c] & pnd;
      ovf_ev  = bus.wr_en[c] & is_full & ~do_pop;
      do_wr   = bus.wr_en[c] & (~ovf_ev | OVW);
      adv_rd  = do_pop | (ovf_ev & OVW);
      rd_d    = adv_rd ? rd_q + AW'(1) : rd_q;
      wr_d    = do_wr ? wr_q + AW'(1) : wr_q;
      cnt_d   = (do_wr & ~adv_rd) ? cnt_q + CW'(1) : (adv_rd & ~do_wr) ? cnt_q - CW'(1) : cnt_q;
      ovf_d   = ovf_ev | (ovf_q & ~bus.clr_ovf[c]);
    end
    // control state, flushed by reset
    always_ff @(posedge clk) begin
      rd_q  <= !reset ? '0 : rd_d;
      wr_q  <= !reset ? '0 : wr_d;
      cnt_q <= !reset ? '0 : cnt_d;
      ovf_q <= !reset ? 1'b0 : ovf_d;
    end
    // storage needs no reset; contents are only visible through count
    always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_q] <= bus.wr_data[c*PCKG_SZ +: PCKG_SZ];
    end
    assign bus.pndng[c]                    = pnd;
    assign bus.full[c]                     = is_full;
    assign bus.overflow[c]                 = ovf_q;
    assign bus.count[c*CW +: CW]           = cnt_q;
    assign bus.D_pop[c*PCKG_SZ +: PCKG_SZ] = pnd ? mem_q[rd_q] : '0;
  end
endmodule

// File: tb/tb_bus_drvr_fifo_bank.sv
// tb_bus_drvr_fifo_bank: directed and random checks of both full-policies against a queue model
module tb_bus_drvr_fifo_bank;
  localparam int NCH = 4;
  localparam int W = 16;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  logic clk = 0;
  logic reset;
  logic [NCH-1:0] wr_en, pop, clr_ovf;
  logic [NCH*W-1:0] wr_data;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  bus_drvr_fifo_bank_if #(.NCH(NCH), .PCKG_SZ(W), .CW(CW)) i0 ();
  bus_drvr_fifo_bank_if #(.NCH(NCH), .PCKG_SZ(W), .CW(CW)) i1 ();
  assign i0.wr_en = wr_en;
  assign i0.wr_data = wr_data;
  assign i0.pop = pop;
  assign i0.clr_ovf = clr_ovf;
  assign i1.wr_en = wr_en;
  assign i1.wr_data = wr_data;
  assign i1.pop = pop;
  assign i1.clr_ovf = clr_ovf;
  bus_drvr_fifo_bank #(.BITS(1), .DRVRS(4), .PCKG_SZ(W), .DEPTH(DEPTH), .OVERWRITE(0)) dut0 (.clk(clk), .reset(reset), .bus(i0));
  bus_drvr_fifo_bank #(.BITS(1), .DRVRS(4), .PCKG_SZ(W), .DEPTH(DEPTH), .OVERWRITE(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // queue model: md[m][c][0] is the head, ms the occupancy; m selects the full-policy
  logic [W-1:0] md [2][NCH][DEPTH+1];
  int ms [2][NCH];
  bit mo [2][NCH];
  bit m_p, m_ev;
  always @(posedge clk) begin
    if (!reset) begin
      started = 1;
      for (int m = 0; m < 2; m++) for (int c = 0; c < NCH; c++) begin ms[m][c] = 0; mo[m][c] = 0; end
    end else begin
      for (int m = 0; m < 2; m++) for (int c = 0; c < NCH; c++) begin
        m_p  = pop[c] && ms[m][c] > 0;
        m_ev = wr_en[c] && ms[m][c] == DEPTH && !m_p;
        if (m_p || (m_ev && m == 1)) begin
          for (int k = 0; k < DEPTH; k++) md[m][c][k] = md[m][c][k+1];
          ms[m][c]--;
        end
        if (wr_en[c] && !(m_ev && m == 0)) begin
          md[m][c][ms[m][c]] = wr_data[c*W +: W];
          ms[m][c]++;
        end
        mo[m][c] = m_ev ? 1'b1 : clr_ovf[c] ? 1'b0 : mo[m][c];
      end
    end
  end

  // every-cycle comparison of both DUTs against the model
  logic [NCH-1:0] ep, ef, eo;
  logic [NCH*W-1:0] ed;
  logic [NCH*CW-1:0] ec;
  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NCH; c++) begin
          ep[c] = ms[m][c] != 0;
          ef[c] = ms[m][c] == DEPTH;
          eo[c] = mo[m][c];
          ec[c*CW +: CW] = CW'(ms[m][c]);
          ed[c*W +: W] = ms[m][c] != 0 ? md[m][c][0] : '0;
        end
        if (m == 0) begin
          chk("m0_pndng", 64'(i0.pndng), 64'(ep));
          chk("m0_full", 64'(i0.full), 64'(ef));
          chk("m0_ovf", 64'(i0.overflow), 64'(eo));
          chk("m0_count", 64'(i0.count), 64'(ec));
          chk("m0_dpop", i0.D_pop, ed);
        end else begin
          chk("m1_pndng", 64'(i1.pndng), 64'(ep));
          chk("m1_full", 64'(i1.full), 64'(ef));
          chk("m1_ovf", 64'(i1.overflow), 64'(eo));
          chk("m1_count", 64'(i1.count), 64'(ec));
          chk("m1_dpop", i1.D_pop, ed);
        end
      end
    end
  end

  function automatic logic [NCH*W-1:0] d1(input int ch, input logic [W-1:0] v);
    logic [NCH*W-1:0] r;
    r = '0;
    r[ch*W +: W] = v;
    return r;
  endfunction

  task automatic step(input logic [NCH-1:0] w, input logic [NCH*W-1:0] d, input logic [NCH-1:0] p, input logic [NCH-1:0] c);
    wr_en = w;
    wr_data = d;
    pop = p;
    clr_ovf = c;
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] v;
  initial begin
    reset = 0;
    wr_en = '0; pop = '0; clr_ovf = '0; wr_data = '0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(4'hF, {4{16'h1234}}, 4'h0, 4'h0);
    chk("rst_pndng", 64'(i0.pndng), 0);
    chk("rst_count", 64'(i0.count), 0);
    chk("rst_dpop", i0.D_pop, 0);
    chk("rst_full", 64'(i0.full), 0);
    chk("rst_ovf", 64'(i0.overflow), 0);
    reset = 1;
    step(0, 0, 0, 0);
    step(4'b0100, d1(2, 16'hA1), 0, 0);
    chk("ch2_pndng1", 64'(i0.pndng), 64'h4);
    chk("ch2_head1", 64'(i0.D_pop[2*W +: W]), 64'hA1);
    chk("ch2_cnt1", 64'(i0.count[2*CW +: CW]), 1);
    step(4'b0100, d1(2, 16'hB2), 0, 0);
    chk("ch2_cnt2", 64'(i0.count[2*CW +: CW]), 2);
    step(4'b0100, d1(2, 16'hC3), 0, 0);
    chk("ch2_cnt3", 64'(i0.count[2*CW +: CW]), 3);
    chk("ch2_headA1", 64'(i0.D_pop[2*W +: W]), 64'hA1);
    step(0, 0, 4'b0100, 0);
    chk("ch2_headB2", 64'(i0.D_pop[2*W +: W]), 64'hB2);
    chk("ch2_cnt2b", 64'(i0.count[2*CW +: CW]), 2);
    step(0, 0, 4'b0100, 0);
    chk("ch2_headC3", 64'(i0.D_pop[2*W +: W]), 64'hC3);
    chk("ch2_cnt1b", 64'(i0.count[2*CW +: CW]), 1);
    chk("ch2_others", 64'(i0.pndng), 64'h4);
    step(0, 0, 4'b0100, 0);
    chk("ch2_cnt0", 64'(i0.count), 0);
    chk("ch2_empty", 64'(i0.pndng), 0);
    for (int k = 0; k < 8; k++) step(4'b0001, d1(0, W'(k)), 0, 0);
    step(4'b0001, d1(0, 16'hFF), 0, 0);
    chk("ovf_full", 64'(i0.full[0]), 1);
    chk("ovf_cnt", 64'(i0.count[0 +: CW]), 8);
    chk("ovf0_flag", 64'(i0.overflow[0]), 1);
    chk("ovf1_flag", 64'(i1.overflow[0]), 1);
    chk("ovf1_cnt", 64'(i1.count[0 +: CW]), 8);
    for (int k = 0; k < 8; k++) begin
      v = k < 7 ? W'(k + 1) : 16'hFF;
      chk("drain0", 64'(i0.D_pop[0 +: W]), 64'(k));
      chk("drain1", 64'(i1.D_pop[0 +: W]), 64'(v));
      step(0, 0, 4'b0001, 0);
    end
    step(0, 0, 0, 4'b0001);
    chk("ovf_clr", 64'(i0.overflow), 0);
    for (int k = 0; k < 8; k++) step(4'b0001, d1(0, W'(16'h10 + k)), 0, 0);
    step(4'b0001, d1(0, 16'h55), 4'b0001, 0);
    chk("wp_cnt0", 64'(i0.count[0 +: CW]), 8);
    chk("wp_cnt1", 64'(i1.count[0 +: CW]), 8);
    chk("wp_ovf0", 64'(i0.overflow[0]), 0);
    chk("wp_ovf1", 64'(i1.overflow[0]), 0);
    step(0, 0, 0, 4'b0001);
    chk("wp_clr_ovf", 64'(i0.overflow[0]), 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("wp_last", 64'(i0.D_pop[0 +: W]), 64'h55);
      step(0, 0, 4'b0001, 0);
    end
    step(4'b1000, d1(3, 16'h3C), 4'b1000, 0);
    chk("e3_cnt", 64'(i0.count[3*CW +: CW]), 1);
    chk("e3_pndng", 64'(i0.pndng[3]), 1);
    chk("e3_dpop", 64'(i0.D_pop[3*W +: W]), 64'h3C);
    step(0, 0, 4'b0010, 0);
    chk("e1_ignored", 64'(i0.count[1*CW +: CW]), 0);
    step(0, 0, 4'b1000, 0);
    for (int k = 0; k < 5; k++) step(4'b0010, d1(1, W'(16'h100 + k)), 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(4'b0010, d1(1, W'(16'h200 + k)), 4'b0010, 0);
      v = k + 1 < 5 ? W'(16'h100 + k + 1) : W'(16'h200 + k - 4);
      chk("wrap_head", 64'(i0.D_pop[1*W +: W]), 64'(v));
      chk("wrap_cnt", 64'(i0.count[1*CW +: CW]), 5);
    end
    reset = 0;
    step(4'b0010, d1(1, 16'h777), 4'b0010, 0);
    chk("mid_rst_cnt", 64'(i0.count), 0);
    chk("mid_rst_pndng", 64'(i0.pndng), 0);
    chk("mid_rst_dpop", i0.D_pop, 0);
    reset = 1;
    for (int k = 0; k < 600; k++) begin
      reset = $urandom_range(0, 63) != 0;
      step(NCH'($urandom), {$urandom, $urandom}, NCH'($urandom & $urandom), NCH'($urandom_range(0, 7) == 0 ? $urandom : 0));
    end
    reset = 1;
    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_drvr_fifo_bank.md
Name: bus_drvr_fifo_bank

Overview:
Bank of BITS x DRVRS independent first-word-fall-through FIFOs, one per bus driver port. It sits between the stimulus agents and the bus DUT. Agents write packets into a channel. The DUT drains them through the same pndng/pop/D_pop handshake it uses on its driver ports. Over the previous fixed-size driver model, it adds configurable depth, per-channel occupancy, sticky overflow and a selectable full-policy (drop-new or overwrite-oldest).

Parameters:
BITS, 1, number of buses
DRVRS, 4, drivers per bus
PCKG_SZ, 16, packet width in bits
DEPTH, 8, entries per FIFO; power of two, >= 2
OVERWRITE, 0, full-policy: 0 = drop incoming write, 1 = discard oldest entry and accept write

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
wr_en  input  NCH  per-channel agent write strobe; NCH = BITS*DRVRS; channel index ch = b*DRVRS + d
wr_data  input  NCH*PCKG_SZ  per-channel write packet; slice [ch*PCKG_SZ +: PCKG_SZ]
pop  input  NCH  per-channel DUT pop strobe
pndng  output  NCH  channel non-empty
D_pop  output  NCH*PCKG_SZ  per-channel head packet; same slicing as wr_data
full  output  NCH  channel holds DEPTH entries
count  output  NCH*CW  per-channel occupancy, 0..DEPTH; CW = $clog2(DEPTH+1)
overflow  output  NCH  sticky: a write arrived while full and no pop occurred that cycle
clr_ovf  input  NCH  per-channel clear of overflow

Behaviour:
- Reset (reset==0 at a clock edge):
  - All pointers, count, pndng, full and overflow go to 0.
  - D_pop reads 0.
  - Memory contents are don't-care.
  - Reset overrides every other input in the same cycle.
  - Reset asserted mid-operation flushes all channels; entries are lost.
- Channels are fully independent. No cross-channel interaction or arbitration.
- Per channel: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is held explicitly, not derived from the pointers.
- pndng = (count != 0) and full = (count == DEPTH); both come from registered count.
- D_pop = mem[rd_ptr] when pndng=1, else 0. This is first-word-fall-through: the head is visible in the same cycle pndng is 1.
- Write-to-pndng latency: a write into an empty channel at edge N gives pndng=1 and valid D_pop after edge N, i.e. 1 cycle.
- Pop: the pop is effective only if pndng=1.
  - An effective pop advances rd_ptr at the edge and decrements count.
  - pop with pndng=0 is ignored, with no error flag.
- Write, not full: the write stores at wr_ptr, advances wr_ptr and increments count.
- Write and effective pop in the same cycle, any fill level including full: both happen and count is unchanged. This is not an overflow.
- Write and pop while empty: the pop is ignored, the write is accepted, count becomes 1.
- Write while full, no effective pop:
  - OVERWRITE=0: the write is discarded. Pointers and count are unchanged. overflow is set.
  - OVERWRITE=1: the write stores at wr_ptr. Both wr_ptr and rd_ptr advance, so the oldest entry is dropped. count stays DEPTH. overflow is set.
- overflow stays set until clr_ovf=1 at an edge. If a set event and clr_ovf occur in the same cycle, set wins.
- count never exceeds DEPTH and never underflows below 0.

Test Plan:
- Reset then idle, BITS=1 DRVRS=4 DEPTH=8 -> all pndng=0, count=0, D_pop=0, full=0, overflow=0. Hold reset=0 while strobing wr_en=4'hF -> outputs stay 0.
- Single channel ch2: write 0xA1, 0xB2, 0xC3 on consecutive cycles, then pop 3 times back-to-back.
  - pndng[2]=1 one cycle after the first write.
  - D_pop[2] reads 0xA1, 0xB2, 0xC3 in order.
  - count goes 1,2,3,2,1,0.
  - Other channels stay empty.
- Fill ch0 with 8 writes (0x00..0x07), then a 9th write 0xFF:
  - OVERWRITE=0 -> full=1, count=8, overflow=1; drain yields 0x00..0x07.
  - OVERWRITE=1 -> drain yields 0x01..0x07,0xFF.
- ch0 full, then write 0x55 with pop in the same cycle -> count stays 8, overflow=0, the last drained value is 0x55. Then assert clr_ovf with no event -> overflow stays 0.
- Empty ch3: simultaneous wr_en=1 (0x3C) and pop=1 -> count=1, pndng=1, D_pop=0x3C. Pop with pndng=0 on ch1 -> no change.
- Wrap-around: 20 write/pop pairs on ch1 with DEPTH=8, then reset=0 asserted mid-stream while count=5 -> data order is preserved across pointer wrap. On the edge after reset, count=0, pndng=0 and D_pop=0.
